// File: rtl/rd_fifo_packer.sv
// Read-FIFO byte packer: assembles 1..N byte controller beats into {error, data} words,
// with an assembly buffer (A) backed by a holding register (H) that feeds the Read FIFO.
module rd_fifo_packer #(
    parameter int RD_FIFO_DATA_WIDTH = 136,
    parameter int ERROR_CODE_WIDTH   = 8,
    parameter int IN_BYTES           = 1,
    parameter int ERROR_MODE         = 0,
    localparam int JUST_DATA_WIDTH   = RD_FIFO_DATA_WIDTH - ERROR_CODE_WIDTH,
    localparam int NUM_BYTES         = JUST_DATA_WIDTH / 8,
    localparam int NUM_BEATS         = NUM_BYTES / IN_BYTES,
    localparam int CW                = $clog2(NUM_BYTES + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    output logic [RD_FIFO_DATA_WIDTH-1:0] o_rd_fifo_data,
    output logic                          o_rd_fifo_we,
    input  logic                          i_rd_fifo_full,
    output logic [CW-1:0]                 o_rd_fifo_bytes,
    input  logic [8*IN_BYTES-1:0]         i_ctrl_data,
    input  logic [ERROR_CODE_WIDTH-1:0]   i_ctrl_error_code,
    input  logic                          i_ctrl_we,
    input  logic                          i_ctrl_flush,
    output logic                          o_ctrl_full
);

    localparam int BCW = $clog2(NUM_BEATS + 1);

    typedef enum logic {
        A_FILL   = 1'b0,
        A_SEALED = 1'b1
    } a_state_t;

    a_state_t                    a_state_r;
    a_state_t                    a_state_nxt_s;
    logic [JUST_DATA_WIDTH-1:0]  a_data_r;
    logic [ERROR_CODE_WIDTH-1:0] a_err_r;
    logic [BCW-1:0]              a_beats_r;
    logic [JUST_DATA_WIDTH-1:0]  beat_top_s;
    logic [JUST_DATA_WIDTH-1:0]  a_data_mrg_s;
    logic [ERROR_CODE_WIDTH-1:0] a_err_mrg_s;
    logic [BCW-1:0]              a_beats_mrg_s;
    logic [CW-1:0]               a_bytes_mrg_s;
    logic [JUST_DATA_WIDTH-1:0]  h_data_r;
    logic [ERROR_CODE_WIDTH-1:0] h_err_r;
    logic [CW-1:0]               h_bytes_r;
    logic                        h_valid_r;
    logic                        beat_acc_s;
    logic                        seal_s;
    logic                        h_free_s;
    logic                        load_h_s;
    logic                        fifo_we_s;
    logic                        ctrl_full_s;

    // Beat merged into A: lane 0 lands at the highest free byte, unfilled bytes of A are already zero.
    always_comb begin
        beat_top_s    = {JUST_DATA_WIDTH{1'b0}};
        for (int j = 0; j < IN_BYTES; j++) begin
            beat_top_s[JUST_DATA_WIDTH-1-8*j -: 8] = i_ctrl_data[8*j +: 8];
        end
        beat_acc_s    = i_ctrl_we & (a_state_r == A_FILL);
        if (beat_acc_s) begin
            a_data_mrg_s  = a_data_r | (beat_top_s >> (a_beats_r * (8 * IN_BYTES)));
            a_err_mrg_s   = (ERROR_MODE == 1) ? (a_err_r | i_ctrl_error_code) : i_ctrl_error_code;
            a_beats_mrg_s = a_beats_r + BCW'(1);
        end else begin
            a_data_mrg_s  = a_data_r;
            a_err_mrg_s   = a_err_r;
            a_beats_mrg_s = a_beats_r;
        end
        a_bytes_mrg_s = CW'(a_beats_mrg_s) * CW'(IN_BYTES);
        seal_s        = (a_state_r == A_FILL) &
                        ((beat_acc_s & (a_beats_mrg_s == BCW'(NUM_BEATS))) |
                         (i_ctrl_flush & (a_beats_mrg_s != {BCW{1'b0}})));
        h_free_s      = ~h_valid_r | fifo_we_s;
        load_h_s      = h_free_s & (seal_s | (a_state_r == A_SEALED));
    end

    // Assembly buffer state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_state_r <= A_FILL;
        end else begin
            a_state_r <= a_state_nxt_s;
        end
    end

    // A waits in SEALED only while the holding register cannot take the finished word.
    always_comb begin
        case (a_state_r)
            A_FILL:   a_state_nxt_s = (seal_s & ~h_free_s) ? A_SEALED : A_FILL;
            A_SEALED: a_state_nxt_s = h_free_s ? A_FILL : A_SEALED;
            default:  a_state_nxt_s = A_FILL;
        endcase
    end

    // Handshake outputs; controller back-pressure depends on state only.
    always_comb begin
        ctrl_full_s = (a_state_r == A_SEALED);
        fifo_we_s   = h_valid_r & ~i_rd_fifo_full;
    end

    // Assembly buffer contents: cleared when handed to H, otherwise accumulate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_data_r  <= {JUST_DATA_WIDTH{1'b0}};
            a_err_r   <= {ERROR_CODE_WIDTH{1'b0}};
            a_beats_r <= {BCW{1'b0}};
        end else if (load_h_s) begin
            a_data_r  <= {JUST_DATA_WIDTH{1'b0}};
            a_err_r   <= {ERROR_CODE_WIDTH{1'b0}};
            a_beats_r <= {BCW{1'b0}};
        end else begin
            a_data_r  <= a_data_mrg_s;
            a_err_r   <= a_err_mrg_s;
            a_beats_r <= a_beats_mrg_s;
        end
    end

    // Holding register: refill takes priority over the drain so a write and reload can share an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_data_r  <= {JUST_DATA_WIDTH{1'b0}};
            h_err_r   <= {ERROR_CODE_WIDTH{1'b0}};
            h_bytes_r <= {CW{1'b0}};
            h_valid_r <= 1'b0;
        end else if (load_h_s) begin
            h_data_r  <= a_data_mrg_s;
            h_err_r   <= a_err_mrg_s;
            h_bytes_r <= a_bytes_mrg_s;
            h_valid_r <= 1'b1;
        end else if (fifo_we_s) begin
            h_valid_r <= 1'b0;
        end else begin
            h_valid_r <= h_valid_r;
        end
    end

    assign o_rd_fifo_data  = {h_err_r, h_data_r};
    assign o_rd_fifo_bytes = h_bytes_r;
    assign o_rd_fifo_we    = fifo_we_s;
    assign o_ctrl_full     = ctrl_full_s;

endmodule

// File: tb/tb_rd_fifo_packer.sv
// Directed bench for rd_fifo_packer: a default-width instance and a 4-byte/OR-policy instance,
// checked every cycle against a word-queue model plus hand-computed literal words.
module tb_rd_fifo_packer;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    logic         a_we, a_flush, a_fifo_full, a_rd_we, a_ctrl_full;
    logic [7:0]   a_data, a_code;
    logic [135:0] a_rd_data;
    logic [4:0]   a_rd_bytes;
    logic         w_we, w_flush, w_fifo_full, w_rd_we, w_ctrl_full;
    logic [31:0]  w_data;
    logic [7:0]   w_code;
    logic [135:0] w_rd_data;
    logic [4:0]   w_rd_bytes;

    rd_fifo_packer u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_rd_fifo_data(a_rd_data), .o_rd_fifo_we(a_rd_we), .i_rd_fifo_full(a_fifo_full),
        .o_rd_fifo_bytes(a_rd_bytes), .i_ctrl_data(a_data), .i_ctrl_error_code(a_code),
        .i_ctrl_we(a_we), .i_ctrl_flush(a_flush), .o_ctrl_full(a_ctrl_full)
    );

    rd_fifo_packer #(.IN_BYTES(4), .ERROR_MODE(1)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_rd_fifo_data(w_rd_data), .o_rd_fifo_we(w_rd_we), .i_rd_fifo_full(w_fifo_full),
        .o_rd_fifo_bytes(w_rd_bytes), .i_ctrl_data(w_data), .i_ctrl_error_code(w_code),
        .i_ctrl_we(w_we), .i_ctrl_flush(w_flush), .o_ctrl_full(w_ctrl_full)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: partial byte list plus up to two finished words waiting for the FIFO.
    logic [7:0]   pbytes [2][16];
    int           pcnt   [2];
    logic [7:0]   perr   [2];
    logic [135:0] wword  [2][2];
    int           wbytes [2][2];
    int           wcnt   [2];

    logic [135:0] log0_data[$];
    int           log0_cyc[$];
    int           log0_bytes[$];
    logic [135:0] log1_data[$];
    int           log1_cyc[$];
    int           log1_bytes[$];
    int           full_cnt0 = 0;
    int           fall_cyc0 = -1;
    logic         prev_full0 = 1'b0;

    function automatic void check(string nm, logic [135:0] act, logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    function automatic logic [127:0] ramp(int s);
        logic [127:0] r;
        r = 128'h0;
        for (int p = 0; p < 16; p++) r[127-8*p -: 8] = 8'(s + p);
        return r;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            pcnt[d] = 0;
            perr[d] = 8'h00;
            wcnt[d] = 0;
        end
    endfunction

    function automatic void model_step(int d, logic we, logic flush, logic [31:0] data,
                                       logic [7:0] code, logic fin, int inb, int mode);
        logic         ofull;
        logic         owe;
        logic [127:0] w;
        ofull = (wcnt[d] == 2);
        owe   = (wcnt[d] >= 1) && !fin;
        if (we && !ofull) begin
            for (int j = 0; j < inb; j++) pbytes[d][pcnt[d]+j] = data[8*j +: 8];
            pcnt[d] += inb;
            perr[d] = (mode == 1) ? (perr[d] | code) : code;
        end
        if (!ofull && (pcnt[d] == 16 || (flush && pcnt[d] > 0))) begin
            w = 128'h0;
            for (int p = 0; p < pcnt[d]; p++) w[127-8*p -: 8] = pbytes[d][p];
            wword[d][wcnt[d]]  = {perr[d], w};
            wbytes[d][wcnt[d]] = pcnt[d];
            wcnt[d]++;
            pcnt[d] = 0;
            perr[d] = 8'h00;
        end
        if (owe) begin
            wword[d][0]  = wword[d][1];
            wbytes[d][0] = wbytes[d][1];
            wcnt[d]--;
        end
    endfunction

    function automatic void check_dut(int d, logic we, logic full, logic [135:0] data,
                                      logic [4:0] bytes, logic fin);
        check($sformatf("dut%0d_ctrl_full", d), 136'(full), 136'(wcnt[d] == 2));
        check($sformatf("dut%0d_fifo_we", d), 136'(we), 136'((wcnt[d] >= 1) && !fin));
        if (wcnt[d] >= 1) begin
            check($sformatf("dut%0d_word", d), data, wword[d][0]);
            check($sformatf("dut%0d_bytes", d), 136'(bytes), 136'(wbytes[d][0]));
        end
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            model_reset();
        end else begin
            model_step(0, a_we, a_flush, {24'h0, a_data}, a_code, a_fifo_full, 1, 0);
            model_step(1, w_we, w_flush, w_data, w_code, w_fifo_full, 4, 1);
        end
    end

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            check_dut(0, a_rd_we, a_ctrl_full, a_rd_data, a_rd_bytes, a_fifo_full);
            check_dut(1, w_rd_we, w_ctrl_full, w_rd_data, w_rd_bytes, w_fifo_full);
            if (a_rd_we) begin
                log0_data.push_back(a_rd_data);
                log0_cyc.push_back(cyc);
                log0_bytes.push_back(int'(a_rd_bytes));
            end
            if (w_rd_we) begin
                log1_data.push_back(w_rd_data);
                log1_cyc.push_back(cyc);
                log1_bytes.push_back(int'(w_rd_bytes));
            end
            if (a_ctrl_full) full_cnt0++;
            if (prev_full0 && !a_ctrl_full) fall_cyc0 = cyc;
            prev_full0 = a_ctrl_full;
        end
    end

    task automatic drive0(logic we, logic [7:0] d, logic [7:0] c, logic fl);
        @(posedge i_clk);
        #1;
        a_we = we; a_data = d; a_code = c; a_flush = fl;
    endtask

    task automatic drive1(logic we, logic [31:0] d, logic [7:0] c, logic fl);
        @(posedge i_clk);
        #1;
        w_we = we; w_data = d; w_code = c; w_flush = fl;
    endtask

    task automatic idle0(int n);
        repeat (n) drive0(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_we0"},    136'(a_rd_we),     136'(0));
        check({tag, "_full0"},  136'(a_ctrl_full), 136'(0));
        check({tag, "_data0"},  a_rd_data,         136'(0));
        check({tag, "_bytes0"}, 136'(a_rd_bytes),  136'(0));
        check({tag, "_we1"},    136'(w_rd_we),     136'(0));
        check({tag, "_full1"},  136'(w_ctrl_full), 136'(0));
        check({tag, "_data1"},  w_rd_data,         136'(0));
        check({tag, "_bytes1"}, 136'(w_rd_bytes),  136'(0));
    endtask

    initial begin
        int n;
        int n0;
        int base;
        int b;
        a_we = 1'b0; a_flush = 1'b0; a_fifo_full = 1'b0; a_data = 8'h00; a_code = 8'h00;
        w_we = 1'b0; w_flush = 1'b0; w_fifo_full = 1'b0; w_data = 32'h0; w_code = 8'h00;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        check_reset_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single full word
        base = log0_cyc.size();
        for (int k = 0; k < 16; k++) drive0(1'b1, 8'(k), (k < 15) ? 8'(k % 5) : 8'h05, 1'b0);
        n = cyc;
        idle0(3);
        check("s1_count", 136'(log0_cyc.size()), 136'(base + 1));
        if (log0_cyc.size() > base) begin
            check("s1_cycle", 136'(log0_cyc[base]), 136'(n + 1));
            check("s1_word", log0_data[base], {8'h05, 128'h000102030405060708090A0B0C0D0E0F});
            check("s1_bytes", 136'(log0_bytes[base]), 136'(16));
        end

        // Streaming 48 beats
        base = log0_cyc.size();
        n0 = 0;
        for (int k = 0; k < 48; k++) begin
            drive0(1'b1, 8'(k), 8'(k), 1'b0);
            if (k == 0) n0 = cyc;
        end
        idle0(3);
        check("s2_count", 136'(log0_cyc.size()), 136'(base + 3));
        check("s2_no_full", 136'(full_cnt0), 136'(0));
        for (int i = 0; i < 3; i++) begin
            if (log0_cyc.size() > base + i) begin
                check("s2_cycle", 136'(log0_cyc[base+i]), 136'(n0 + 16 * (i + 1)));
                check("s2_word", log0_data[base+i], {8'(16 * i + 15), ramp(16 * i)});
            end
        end

        // Back-pressure with the FIFO full
        base = log0_cyc.size();
        @(posedge i_clk);
        #1;
        a_fifo_full = 1'b1;
        b = 0;
        for (int i = 0; i < 40; i++) begin
            drive0(1'b1, 8'(8'h20 + b), 8'(b), 1'b0);
            if (!a_ctrl_full) b++;
        end
        check("s3_accepted", 136'(b), 136'(32));
        check("s3_full_high", 136'(a_ctrl_full), 136'(1));
        check("s3_no_write", 136'(log0_cyc.size()), 136'(base));
        @(posedge i_clk);
        #1;
        a_fifo_full = 1'b0;
        n = cyc;
        for (int i = 0; i < 30 && b < 48; i++) begin
            drive0(1'b1, 8'(8'h20 + b), 8'(b), 1'b0);
            if (!a_ctrl_full) b++;
        end
        idle0(3);
        check("s3_count", 136'(log0_cyc.size()), 136'(base + 3));
        check("s3_full_fall", 136'(fall_cyc0), 136'(n + 1));
        if (log0_cyc.size() >= base + 3) begin
            check("s3_w1_cycle", 136'(log0_cyc[base]), 136'(n));
            check("s3_w2_cycle", 136'(log0_cyc[base+1]), 136'(n + 1));
            check("s3_w1", log0_data[base],   {8'h0F, ramp(8'h20)});
            check("s3_w2", log0_data[base+1], {8'h1F, ramp(8'h30)});
            check("s3_w3", log0_data[base+2], {8'h2F, ramp(8'h40)});
        end

        // Flush with a beat in the same cycle, then a flush on an empty buffer
        base = log0_cyc.size();
        drive0(1'b1, 8'hAA, 8'h00, 1'b0);
        drive0(1'b1, 8'hBB, 8'h00, 1'b0);
        drive0(1'b1, 8'hCC, 8'h07, 1'b1);
        n = cyc;
        idle0(3);
        check("s4_count", 136'(log0_cyc.size()), 136'(base + 1));
        if (log0_cyc.size() > base) begin
            check("s4_cycle", 136'(log0_cyc[base]), 136'(n + 1));
            check("s4_word", log0_data[base], {8'h07, 24'hAABBCC, 104'h0});
            check("s4_bytes", 136'(log0_bytes[base]), 136'(3));
        end
        base = log0_cyc.size();
        drive0(1'b0, 8'h00, 8'h00, 1'b1);
        idle0(4);
        check("s4_empty_flush", 136'(log0_cyc.size()), 136'(base));

        // Wide beats with OR error policy
        drive1(1'b1, 32'h03020100, 8'h01, 1'b0);
        drive1(1'b1, 32'h07060504, 8'h04, 1'b0);
        drive1(1'b1, 32'h0B0A0908, 8'h00, 1'b0);
        drive1(1'b1, 32'h0F0E0D0C, 8'h10, 1'b0);
        n = cyc;
        repeat (3) drive1(1'b0, 32'h0, 8'h00, 1'b0);
        check("s5_count", 136'(log1_cyc.size()), 136'(1));
        if (log1_cyc.size() > 0) begin
            check("s5_cycle", 136'(log1_cyc[0]), 136'(n + 1));
            check("s5_word", log1_data[0], {8'h15, 128'h000102030405060708090A0B0C0D0E0F});
            check("s5_bytes", 136'(log1_bytes[0]), 136'(16));
        end

        // Reset in the middle of a word
        for (int k = 0; k < 7; k++) drive0(1'b1, 8'(8'h50 + k), 8'h09, 1'b0);
        idle0(1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        base = log0_cyc.size();
        for (int k = 0; k < 16; k++) drive0(1'b1, 8'(8'h80 + k), 8'h33, 1'b0);
        idle0(3);
        check("s6_count", 136'(log0_cyc.size()), 136'(base + 1));
        if (log0_cyc.size() > base) begin
            check("s6_word", log0_data[base], {8'h33, ramp(8'h80)});
            check("s6_bytes", 136'(log0_bytes[base]), 136'(16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
